// File: rtl/fifo_row_feeder_if.sv
// rtl/fifo_row_feeder_if.sv - command, FIFO read-side and operand-stream bundle for one feeder lane
interface fifo_row_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 5
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  count;
  logic                  abort;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  busy;
  logic                  done;
  logic                  underrun;

  modport master (
    output start, count, abort, fifo_empty, fifo_data,
    input  fifo_read, out_data, out_valid, busy, done, underrun
  );

  modport slave (
    input  start, count, abort, fifo_empty, fifo_data,
    output fifo_read, out_data, out_valid, busy, done, underrun
  );
endinterface

// File: rtl/fifo_row_feeder.sv
// rtl/fifo_row_feeder.sv - FIFO-to-systolic-row burst feeder with per-row skew
// Optional FEEDER_ZERO_FILL_EN: empty read slots emit zero operands instead of stalling.
module fifo_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 5,
  parameter int SKEW       = 0
) (
  input  logic             clk,
  input  logic             reset,
  fifo_row_feeder_if.slave bus
);
  localparam int SKW = (SKEW > 1) ? $clog2(SKEW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SKEW, S_READ, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SKW-1:0]        r_skew;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_done;
  logic                  r_underrun;
`ifdef FEEDER_ZERO_FILL_EN
  logic                  r_pend_zero;
`endif

  logic w_accept;
  logic w_zero_req;
  logic w_cancel;
  logic w_read;
  logic w_empty_due;
  logic w_slot;
  logic w_busy;

  assign w_accept   = (r_state == S_IDLE) && bus.start && (bus.count != '0);
  assign w_zero_req = (r_state == S_IDLE) && bus.start && (bus.count == '0);
  assign w_cancel   = (r_state != S_IDLE) && bus.abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (SKEW > 0) ? S_SKEW : S_READ;
      S_SKEW:  if (bus.abort) w_next = S_IDLE;
               else if (r_skew == '0) w_next = S_READ;
      S_READ:  if (bus.abort) w_next = S_IDLE;
               else if (w_slot && (r_rem == CNT_WIDTH'(1))) w_next = S_DRAIN;
      // Leave once the last word is on the output and nothing is still in flight.
      S_DRAIN: if (bus.abort) w_next = S_IDLE;
               else if (r_out_valid && !r_pend) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_read      = 1'b0;
    w_empty_due = 1'b0;
    w_busy      = (r_state != S_IDLE);
    if (r_state == S_READ && !bus.abort) begin
      w_read      = !bus.fifo_empty;
      w_empty_due = bus.fifo_empty;
    end
`ifdef FEEDER_ZERO_FILL_EN
    w_slot = w_read || w_empty_due;
`else
    w_slot = w_read;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skew      <= '0;
      r_rem       <= '0;
      r_pend      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef FEEDER_ZERO_FILL_EN
      r_pend_zero <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_skew <= SKW'((SKEW > 0) ? SKEW - 1 : 0);
      end else if (r_state == S_SKEW && r_skew != '0) begin
        r_skew <= r_skew - SKW'(1);
      end

      if (w_accept)    r_rem <= bus.count;
      else if (w_slot) r_rem <= r_rem - CNT_WIDTH'(1);

      r_pend      <= w_slot;
      r_out_valid <= r_pend && !w_cancel;
`ifdef FEEDER_ZERO_FILL_EN
      r_pend_zero <= w_empty_due;
      if (r_pend && !w_cancel) r_out_data <= r_pend_zero ? '0 : bus.fifo_data;
`else
      if (r_pend && !w_cancel) r_out_data <= bus.fifo_data;
`endif

      // The first DRAIN cycle always holds the final slot one stage from the output.
      r_done <= w_zero_req || (r_state == S_DRAIN && r_pend && !bus.abort);

      if (r_state == S_IDLE && bus.start) r_underrun <= 1'b0;
      else if (w_empty_due)               r_underrun <= 1'b1;
    end
  end

  assign bus.fifo_read = w_read;
  assign bus.busy      = w_busy;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;
  assign bus.underrun  = r_underrun;
endmodule

// File: tb/tb_fifo_row_feeder.sv
// tb/tb_fifo_row_feeder.sv - directed vector bench for fifo_row_feeder (SKEW=0 and SKEW=2 lanes)
module tb_fifo_row_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_row_feeder_if #(.DATA_WIDTH(8), .CNT_WIDTH(5)) if0 ();
  fifo_row_feeder_if #(.DATA_WIDTH(8), .CNT_WIDTH(5)) if2 ();

  fifo_row_feeder #(.DATA_WIDTH(8), .CNT_WIDTH(5), .SKEW(0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
  fifo_row_feeder #(.DATA_WIDTH(8), .CNT_WIDTH(5), .SKEW(2)) dut2 (.clk(clk), .reset(rst), .bus(if2));

  // FIFO models: pushes from the stimulus side at negedge, pops on posedge reads.
  logic [7:0] mem0 [64];
  logic [7:0] mem2 [64];
  int wp0 = 0, rp0 = 0, wp2 = 0, rp2 = 0;
  logic [7:0] fd0 = 8'h0, fd2 = 8'h0;

  always @(posedge clk) begin
    if (if0.fifo_read) begin
      fd0 <= mem0[rp0[5:0]];
      rp0 <= rp0 + 1;
    end
    if (if2.fifo_read) begin
      fd2 <= mem2[rp2[5:0]];
      rp2 <= rp2 + 1;
    end
  end

  assign if0.fifo_empty = (wp0 == rp0);
  assign if0.fifo_data  = fd0;
  assign if2.fifo_empty = (wp2 == rp2);
  assign if2.fifo_data  = fd2;

  typedef struct {
    string       nm;
    int          sel;
    logic        st;
    logic [4:0]  cnt;
    logic        ab;
    logic        fl;
    int          np;
    logic [31:0] pv;
    logic [12:0] exp;
  } vec_t;

  vec_t tv[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void add(string nm, int sel, logic st, int cnt, logic ab, logic fl, int np,
                              logic [31:0] pv, logic rd, logic ov, logic [7:0] od,
                              logic bz, logic dn, logic un);
    vec_t v;
    v.nm  = nm;
    v.sel = sel;
    v.st  = st;
    v.cnt = 5'(cnt);
    v.ab  = ab;
    v.fl  = fl;
    v.np  = np;
    v.pv  = pv;
    v.exp = {rd, ov, od, bz, dn, un};
    tv.push_back(v);
  endfunction

  function automatic logic [12:0] get(int sel);
    if (sel == 0)
      return {if0.fifo_read, if0.out_valid, if0.out_data, if0.busy, if0.done, if0.underrun};
    return {if2.fifo_read, if2.out_valid, if2.out_data, if2.busy, if2.done, if2.underrun};
  endfunction

  task automatic check(string nm, logic [12:0] act, logic [12:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rd=%b ov=%b od=%0d busy=%b done=%b underrun=%b, expected rd=%b ov=%b od=%0d busy=%b done=%b underrun=%b",
               nm, act[12], act[11], act[10:3], act[2], act[1], act[0],
               exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(vec_t v);
    if0.start = (v.sel == 0) ? v.st : 1'b0;
    if0.count = (v.sel == 0) ? v.cnt : 5'd0;
    if0.abort = (v.sel == 0) ? v.ab : 1'b0;
    if2.start = (v.sel == 2) ? v.st : 1'b0;
    if2.count = (v.sel == 2) ? v.cnt : 5'd0;
    if2.abort = (v.sel == 2) ? v.ab : 1'b0;
    if (v.fl) begin
      if (v.sel == 0) wp0 = rp0;
      else            wp2 = rp2;
    end
    for (int k = 0; k < v.np; k++) begin
      if (v.sel == 0) begin
        mem0[wp0[5:0]] = v.pv[8*k +: 8];
        wp0++;
      end else begin
        mem2[wp2[5:0]] = v.pv[8*k +: 8];
        wp2++;
      end
    end
  endtask

  task automatic run_range(int lo, int hi);
    logic [12:0] act;
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      act = get(tv[i].sel);
      if (!tv[i].exp[11]) act[10:3] = 8'h0;
      check(tv[i].nm, act, tv[i].exp);
    end
  endtask

  initial begin
    int seg;
    logic [12:0] act;
    if0.start = 0; if0.count = 0; if0.abort = 0;
    if2.start = 0; if2.count = 0; if2.abort = 0;

    // A: SKEW=2, preload 1..4, count=4
    add("A_c0", 2, 1, 4, 0, 1, 4, 32'h04030201, 0, 0, 0, 0, 0, 0);
    add("A_c1", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("A_c2", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("A_c3", 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("A_c4", 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("A_c5", 2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    add("A_c6", 2, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 0);
    add("A_c7", 2, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    add("A_c8", 2, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0);
    add("A_c9", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // B: count=0
    add("B_c0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("B_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("B_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // C: two words, then empty, refill 7,8 at cycle 5
    add("C_c0", 0, 1, 4, 0, 1, 2, 32'h00000605, 0, 0, 0, 0, 0, 0);
    add("C_c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("C_c2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("C_c3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    add("C_c4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 1);
`ifdef FEEDER_ZERO_FILL_EN
    add("C_c5", 0, 0, 0, 0, 0, 2, 32'h00000807, 0, 1, 0, 1, 0, 1);
    add("C_c6", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    add("C_c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("C_c8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
    add("C_c5", 0, 0, 0, 0, 0, 2, 32'h00000807, 1, 0, 0, 1, 0, 1);
    add("C_c6", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add("C_c7", 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 1);
    add("C_c8", 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 1, 1);
    add("C_c9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    // D: abort in cycle 3 of a count=6 burst
    add("D_c0", 0, 1, 6, 0, 1, 4, 32'h0E0D0C0B, 0, 0, 0, 0, 0, 1);
    add("D_c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("D_c2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("D_c3", 0, 0, 0, 1, 0, 0, 0, 0, 1, 11, 1, 0, 0);
    add("D_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("D_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // F: start while busy is ignored
    add("F_c0", 0, 1, 3, 0, 1, 3, 32'h00171615, 0, 0, 0, 0, 0, 0);
    add("F_c1", 0, 1, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("F_c2", 0, 1, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("F_c3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 21, 1, 0, 0);
    add("F_c4", 0, 1, 2, 0, 0, 0, 0, 0, 1, 22, 1, 0, 0);
    add("F_c5", 0, 0, 0, 0, 0, 0, 0, 0, 1, 23, 1, 1, 0);
    add("F_c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("F_c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seg = tv.size();
    // After mid-burst reset: SKEW=2, count=2
    add("R_c0", 2, 1, 2, 0, 1, 2, 32'h00000201, 0, 0, 0, 0, 0, 0);
    add("R_c1", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("R_c2", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("R_c3", 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("R_c4", 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add("R_c5", 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    add("R_c6", 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0);
    add("R_c7", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    check("reset_dut0", get(0), 13'h0);
    check("reset_dut2", get(2), 13'h0);
    rst = 1'b0;

    run_range(0, seg);

    // Reset asserted asynchronously in cycle 6 of a SKEW=2 count=4 burst
    @(negedge clk);
    wp2 = rp2;
    for (int k = 1; k <= 4; k++) begin
      mem2[wp2[5:0]] = 8'(k);
      wp2++;
    end
    if2.start = 1'b1;
    if2.count = 5'd4;
    @(negedge clk);
    if2.start = 1'b0;
    if2.count = 5'd0;
    repeat (5) @(negedge clk);
    #1;
    act = get(2);
    check("rst_pre", act, {1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    #1;
    check("rst_async", get(2), 13'h0);
    @(negedge clk);
    rst = 1'b0;

    run_range(seg, tv.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_row_feeder.md
# fifo_row_feeder

Read-side controller for one FIFO lane: on a start command it pulls a burst of `count` words out of a FIFO and presents them as a one-word-per-cycle operand stream to one systolic-array row. A per-instance skew delay staggers the rows. It drives the FIFO's `read` input and consumes its `fifo_empty` and `data_out` outputs. It reports busy, done and a sticky underrun flag to the array sequencer.

## Interface
- `DATA_WIDTH`, 8, operand/FIFO word width
- `CNT_WIDTH`, 5, width of the burst length field (max burst 2^CNT_WIDTH-1)
- `SKEW`, 0, idle cycles inserted between start acceptance and the first FIFO read (row index in the array)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `start` in 1: burst request, sampled in IDLE only
- `count` in CNT_WIDTH: burst length, sampled with `start`
- `abort` in 1: synchronous cancel of the running burst
- `fifo_empty` in 1: FIFO empty status
- `fifo_data` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_read`
- `fifo_read` out 1: FIFO read strobe
- `out_data` out DATA_WIDTH: operand to the array row, registered
- `out_valid` out 1: `out_data` carries a burst slot
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse, burst complete
- `underrun` out 1: sticky; FIFO was empty while a read was due

## Operation
- States: IDLE, SKEW, READ, DRAIN.
- Reset value of every output: `fifo_read` 0, `out_data` 0, `out_valid` 0, `busy` 0, `done` 0, `underrun` 0. State is IDLE; the remaining-count register is 0.
- IDLE, `start`=1, `count`>0: latch `count` and clear `underrun`. Go to SKEW if `SKEW`>0, else go to READ.
- IDLE, `start`=1, `count`=0: pulse `done` next cycle. No reads. Stay IDLE. `underrun` is cleared.
- `start` outside IDLE is ignored.
- SKEW: count down `SKEW` cycles, then go to READ.
- READ: `fifo_read` = !`fifo_empty` (combinational from state and `fifo_empty`).
  - Each issued read consumes one slot.
  - After the last slot's read, go to DRAIN.
- READ with `fifo_empty`=1: set `underrun`. Slot behaviour is set by the Configuration macro.
- DRAIN: wait for the last in-flight word. Return to IDLE the cycle after the final `out_valid`.
- `fifo_read` is never asserted while `fifo_empty`=1. The FIFO therefore never sees an underflow from this block.
- `abort` in SKEW/READ/DRAIN:
  - Next state IDLE; `fifo_read` is deasserted the same cycle.
  - An in-flight word is dropped (no `out_valid`). `done` is not pulsed; `underrun` is kept.
- `abort` in IDLE has no effect. `abort` and `start` in the same IDLE cycle: `start` wins.
- `reset` mid-burst: all outputs go to reset values asynchronously. A FIFO word read in the previous cycle is lost.
- `out_data` holds its last value while `out_valid`=0.

## Timing
- `start` is sampled at the end of cycle 0; `busy`=1 from cycle 1.
- Let R = 1 + `SKEW`. With no empties, `fifo_read`=1 in cycles R .. R+count-1.
- Read-to-output latency is 2 cycles. A read in cycle t gives `fifo_data` in t+1, registered to `out_data`/`out_valid` in t+2.
- With no stalls, `out_valid` is high in cycles R+2 .. R+count+1, back-to-back.
- `done` is high together with the last `out_valid`. `busy` drops the following cycle.
- `underrun` is visible in the cycle after the empty READ cycle.
- Next `start` is accepted in the first cycle with `busy`=0.

## Configuration
- `FEEDER_ZERO_FILL_EN` defined:
  - An empty READ cycle still consumes a slot.
  - 2 cycles later, `out_valid`=1 with `out_data`=0, preserving systolic cadence.
  - The burst always lasts exactly `count` output cycles.
- Undefined:
  - An empty READ cycle is a stall: no slot consumed, and `out_valid`=0 in the matching output cycle.
  - The burst waits for data and still delivers `count` real words.
- `underrun` is set in both builds.

## Test plan
- SKEW=2, FIFO preloaded 1,2,3,4, start count=4 at cycle 0 -> `fifo_read` cycles 3-6. `out_valid` with 1,2,3,4 in cycles 5-8. `done` cycle 8, `busy` low cycle 9.
- Start with count=0 -> `done` pulse cycle 1, `fifo_read` never high, `busy` stays 0.
- SKEW=0, FIFO holds 2 words (5,6), count=4, FIFO refilled with 7,8 at cycle 5:
  - `FEEDER_ZERO_FILL_EN` -> out 5,6,0,0 in cycles 3-6.
  - Without it -> out 5,6 then a gap, then 7,8; `done` with 8.
  - `underrun`=1 in both builds.
- Abort in cycle 3 of a count=6 burst (SKEW=0) -> `fifo_read` low from cycle 3. At most words from reads in cycles 1-2 appear. No `done`; `busy` 0 in cycle 4.
- Reset asserted mid-READ -> all outputs 0 in the same cycle. After release, a new start count=2 behaves as the first scenario.
- Start asserted while `busy`=1 -> ignored; the burst completes unchanged and a single `done` is seen.
